downcounter: RTL and testbench

//  Loadable down-counter/timer, the counterpart of the up-counter: counts from a loaded start value

---
 rtl/downcounter_pkg.sv | 10 +
 rtl/downcounter.sv | 87 ++++++++
 tb/tb_downcounter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/downcounter_pkg.sv
// rtl/downcounter_pkg.sv - shared state encoding for the loadable down-counter
package downcounter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/downcounter.sv
// rtl/downcounter.sv - loadable down-counter/timer with load handshake and done acknowledge
// Optional pause input Hold_i is built when DOWNCOUNTER_HOLD_EN is defined.
module downcounter
    import downcounter_pkg::*;
#(
    parameter int unsigned       Width = 32,
    parameter logic [Width-1:0]  Init  = Width'(64),
    parameter logic [Width-1:0]  Final = Width'(8)
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic             Load_valid_i,
    input  logic [Width-1:0] Load_data_i,
    output logic             Load_ready_o,
    output logic [Width-1:0] Data_o,
    output logic             Done_o,
`ifdef DOWNCOUNTER_HOLD_EN
    input  logic             Hold_i,
`endif
    input  logic             Done_ack_i
);

    state_t           state_q;
    logic [Width-1:0] data_q;
    logic             done_q;

    logic             hold;
    logic             load_fire;
    logic             load_runs;
    logic [Width-1:0] load_value;

`ifdef DOWNCOUNTER_HOLD_EN
    assign hold = Hold_i;
`else
    assign hold = 1'b0;
`endif

    assign Load_ready_o = (state_q == IDLE) || (state_q == DONE);
    assign load_fire    = Load_valid_i && Load_ready_o;

    // Start values at or below the terminal count clamp and go straight to DONE.
    assign load_runs  = (Load_data_i > Final);
    assign load_value = load_runs ? Load_data_i : Final;

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q <= IDLE;
            data_q  <= Init;
            done_q  <= 1'b0;
        end else if (load_fire) begin
            data_q  <= load_value;
            state_q <= load_runs ? RUN : DONE;
            done_q  <= !load_runs;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                end
                RUN: begin
                    if (!hold) begin
                        if (data_q == Final + 1'b1) begin
                            data_q  <= Final;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            data_q  <= data_q - 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (Done_ack_i) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Data_o = data_q;
    assign Done_o = done_q;

endmodule

// File: tb/tb_downcounter.sv
// tb/tb_downcounter.sv - randomized and directed bench for downcounter against a behavioural model
module tb_downcounter;

    localparam int unsigned W = 32;

    logic          clk;
    logic          rst;
    logic          valid;
    logic [W-1:0]  ldata;
    logic          ready;
    logic [W-1:0]  data;
    logic          done;
    logic          ack;
    logic          hold;

    int total = 0;
    int bad   = 0;

    downcounter #(.Width(W), .Init(32'd64), .Final(32'd8)) dut (
        .Clk_i        (clk),
        .Reset_i      (rst),
        .Load_valid_i (valid),
        .Load_data_i  (ldata),
        .Load_ready_o (ready),
        .Data_o       (data),
        .Done_o       (done),
`ifdef DOWNCOUNTER_HOLD_EN
        .Hold_i       (hold),
`endif
        .Done_ack_i   (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a count plus "running" and "finished" flags.
    logic [W-1:0] m_cnt;
    bit           m_run;
    bit           m_done;
    bit           m_valid = 0;

    always @(posedge clk) begin
        bit hold_eff;
`ifdef DOWNCOUNTER_HOLD_EN
        hold_eff = hold;
`else
        hold_eff = 0;
`endif
        if (rst) begin
            m_cnt = 64; m_run = 0; m_done = 0; m_valid = 1;
        end else if (!m_run && valid) begin
            if (ldata > 8) begin
                m_cnt = ldata; m_run = 1; m_done = 0;
            end else begin
                m_cnt = 8; m_run = 0; m_done = 1;
            end
        end else if (m_run) begin
            if (!hold_eff) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 8) begin
                    m_run = 0; m_done = 1;
                end
            end
        end else if (m_done && ack) begin
            m_done = 0;
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_data",  data,  m_cnt);
            check("model_done",  W'(done),  W'(m_done));
            check("model_ready", W'(ready), W'(!m_run));
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        valid = 0; ldata = '0; ack = 0; hold = 0; rst = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        tick();
        rst = 0;
        tick();
        check("reset_data",  data, 32'd64);
        check("reset_done",  W'(done), 32'd0);
        check("reset_ready", W'(ready), 32'd1);
        tick();
        check("idle_holds",  data, 32'd64);

        // Load 12: 12,11,10,9 then 8 with done.
        valid = 1; ldata = 12;
        tick();
        valid = 0;
        for (int i = 0; i < 4; i++) begin
            check("run_data",  data, 32'(12 - i));
            check("run_ready", W'(ready), 32'd0);
            check("run_done",  W'(done), 32'd0);
            tick();
        end
        check("term_data", data, 32'd8);
        check("term_done", W'(done), 32'd1);
        check("term_ready", W'(ready), 32'd1);

        // Ack and load same edge: load wins.
        valid = 1; ldata = 20; ack = 1;
        tick();
        valid = 0; ack = 0;
        check("ackload_data", data, 32'd20);
        check("ackload_done", W'(done), 32'd0);
        repeat (12) tick();
        check("reach_final", data, 32'd8);
        ack = 1;
        tick();
        ack = 0;
        check("ack_idle_data",  data, 32'd8);
        check("ack_idle_done",  W'(done), 32'd0);
        check("ack_idle_ready", W'(ready), 32'd1);

        // Load below Final clamps straight to DONE.
        valid = 1; ldata = 5;
        tick();
        valid = 0;
        check("clamp_data", data, 32'd8);
        check("clamp_done", W'(done), 32'd1);
        ack = 1;
        tick();
        ack = 0;

        // Load 40, a held valid during RUN is ignored, reset mid-run.
        valid = 1; ldata = 40;
        tick();
        ldata = 5;
        tick();
        check("ignored_load", data, 32'd39);
        tick();
        rst = 1;
        tick();
        rst = 0; valid = 0;
        check("midrun_reset_data", data, 32'd64);
        check("midrun_reset_done", W'(done), 32'd0);
        check("midrun_reset_ready", W'(ready), 32'd1);

`ifdef DOWNCOUNTER_HOLD_EN
        valid = 1; ldata = 10;
        tick();
        valid = 0;
        tick();
        check("hold_pre", data, 32'd9);
        hold = 1;
        repeat (3) tick();
        hold = 0;
        check("hold_frozen", data, 32'd9);
        tick();
        check("hold_post", data, 32'd8);
        check("hold_done", W'(done), 32'd1);
        ack = 1;
        tick();
        ack = 0;
`endif

        // Randomized phase, checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 99) < 2);
            valid = ($urandom_range(0, 99) < 30);
            ldata = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 200)) : W'($urandom_range(0, 30));
            ack   = ($urandom_range(0, 99) < 30);
            hold  = ($urandom_range(0, 99) < 30);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
